// File: rtl/mem_port_arbiter_if.sv
// Purpose : request/grant/response bundle between the two pipeline requesters, the arbiter and memory.
// Latency : none, wires only.
// Backpressure: requesters hold req until gnt; the arbiter accepts one transaction at a time.
// Modports: slave  = arbiter view (takes requests and mem_ack/mem_rdata, drives gnt/rvalid/rdata/mem cmd/err)
//           master = environment view (fetch and data requesters plus the memory model)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    // data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // memory command / completion
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between fetch (IF) and load/store (MEM); data wins, fetch forced after STARVE_MAX losses.
// Latency : req sampled in IDLE at N -> gnt+mem_en at N+1 -> rvalid one cycle after mem_ack (earliest N+2); 3-cycle minimum period.
// Backpressure: requesters hold req until their gnt pulse; one transaction outstanding; BUSY ends on mem_ack or after TIMEOUT cycles (err).
// Ports: clk, reset (async, active-low), bus (mem_port_arbiter_if.slave: per-requester req/gnt/rvalid/rdata, memory command, err).
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int TC_W = $clog2(TIMEOUT);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [TC_W-1:0] TMO_LAST   = TC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [TC_W-1:0]   tmo_q;

    logic              fetch_wins, data_wins, in_busy, done, timed_out;
    logic [DATA_W-1:0] resp_data;

    // next values of the registered outputs
    logic              if_gnt_d, d_gnt_d, mem_en_d, if_rvalid_d, d_rvalid_d, err_d;

    // registered outputs and latched command
    logic              if_gnt_q, d_gnt_q, mem_en_q, mem_we_q, if_rvalid_q, d_rvalid_q, err_q;
    logic [31:0]       if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;

    // Arbitration and completion decode. Requests only matter in IDLE;
    // mem_ack only matters in BUSY_x.
    always_comb begin
        fetch_wins = bus.if_req && (!bus.d_req || (starve_q == STARVE_LIM));
        data_wins  = bus.d_req && !fetch_wins;
        in_busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
        // ack on the last allowed cycle still counts as a normal completion
        timed_out  = in_busy && !bus.mem_ack && (tmo_q == TMO_LAST);
        done       = in_busy && (bus.mem_ack || (tmo_q == TMO_LAST));
        resp_data  = bus.mem_ack ? bus.mem_rdata : '0;
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            // counter is 0 on BUSY entry and back to 0 once BUSY is left
            tmo_q    <= (in_busy && !done) ? tmo_q + 1'b1 : '0;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (data_wins)       state_d = BUSY_D;
                else if (fetch_wins) state_d = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (done) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // output logic: values the output registers take at the next edge
    always_comb begin
        if_gnt_d    = (state_q == IDLE) && fetch_wins;
        d_gnt_d     = (state_q == IDLE) && data_wins;
        mem_en_d    = if_gnt_d || d_gnt_d;
        if_rvalid_d = (state_q == BUSY_I) && done;
        d_rvalid_d  = (state_q == BUSY_D) && done;
        err_d       = timed_out;

        // starvation count: consecutive data grants made while fetch was waiting
        starve_d = starve_q;
        if (d_gnt_d) begin
            if (!bus.if_req)              starve_d = '0;
            else if (starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
        end else if (if_gnt_d) begin
            starve_d = '0;
        end
    end

    // output registers and command latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            mem_en_q    <= mem_en_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            err_q       <= err_d;
            // command stays latched through BUSY and until the next grant
            if (mem_en_d) begin
                mem_addr_q  <= data_wins ? bus.d_addr : bus.if_addr;
                mem_we_q    <= data_wins && bus.d_we;
                mem_wdata_q <= (data_wins && bus.d_we) ? bus.d_wdata : '0;
            end
            // read data holds until the owner's next response
            if (if_rvalid_d) if_rdata_q <= resp_data[31:0];
            if (d_rvalid_d)  d_rdata_q  <= mem_we_q ? '0 : resp_data;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs a transaction-level model.
// Latency : model predicts gnt one cycle after an IDLE sample and rvalid one cycle after ack/timeout.
// Backpressure: bench requesters hold req until gnt; memory responder acks with fixed delay, randomly, or never.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // ---------------- transaction-level model ----------------
    // A transaction opens when a request is sampled while free, closes with a
    // response after ack or TIMEOUT busy cycles, and the port is free again
    // one cycle after the response.
    logic              e_if_gnt, e_d_gnt, e_mem_en, e_mem_we, e_if_rvalid, e_d_rvalid, e_err;
    logic [31:0]       e_if_rdata;
    logic [DATA_W-1:0] e_d_rdata, e_mem_wdata;
    logic [ADDR_W-1:0] e_mem_addr;
    bit                m_busy, m_resp, m_own_d, m_we;
    int                m_age, m_starve;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                {e_if_gnt, e_d_gnt, e_mem_en, e_mem_we, e_if_rvalid, e_d_rvalid, e_err} = '0;
                e_if_rdata = '0; e_d_rdata = '0; e_mem_wdata = '0; e_mem_addr = '0;
                m_busy = 0; m_resp = 0; m_own_d = 0; m_we = 0; m_age = 0; m_starve = 0;
            end else begin
                bit take_i, take_d;
                logic [DATA_W-1:0] data;
                {e_if_gnt, e_d_gnt, e_mem_en, e_if_rvalid, e_d_rvalid, e_err} = '0;
                if (m_resp) begin
                    m_resp = 0;
                    m_busy = 0;
                end else if (!m_busy) begin
                    take_i = bus.if_req && (!bus.d_req || m_starve == STARVE_MAX);
                    take_d = bus.d_req && !take_i;
                    if (take_i || take_d) begin
                        m_busy      = 1;
                        m_age       = 0;
                        m_own_d     = take_d;
                        m_we        = take_d && bus.d_we;
                        e_if_gnt    = take_i;
                        e_d_gnt     = take_d;
                        e_mem_en    = 1;
                        e_mem_we    = m_we;
                        e_mem_addr  = take_d ? bus.d_addr : bus.if_addr;
                        e_mem_wdata = m_we ? bus.d_wdata : '0;
                        if (take_d) m_starve = bus.if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                        else        m_starve = 0;
                    end
                end else begin
                    if (bus.mem_ack || m_age == TIMEOUT - 1) begin
                        data   = bus.mem_ack ? bus.mem_rdata : '0;
                        e_err  = !bus.mem_ack;
                        m_resp = 1;
                        if (m_own_d) begin
                            e_d_rvalid = 1;
                            e_d_rdata  = m_we ? '0 : data;
                        end else begin
                            e_if_rvalid = 1;
                            e_if_rdata  = data[31:0];
                        end
                    end else begin
                        m_age++;
                    end
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    // ---------------- environment state ----------------
    int                ack_mode  = 0;   // 0 never, 1 fixed delay after mem_en, 2 random
    int                ack_delay = 1;
    bit                fix_rdata = 0;
    logic [DATA_W-1:0] fix_val   = '0;
    bit                ack_pend  = 0;
    int                ack_wait  = 0;
    bit                rand_req  = 0;
    bit                req_always = 0;

    // One cycle: compare DUT to model at the falling edge, then drive
    // the memory responder and (optionally) the random requesters.
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            chk1("if_gnt",    bus.if_gnt,    e_if_gnt);
            chk1("d_gnt",     bus.d_gnt,     e_d_gnt);
            chk1("mem_en",    bus.mem_en,    e_mem_en);
            chk1("if_rvalid", bus.if_rvalid, e_if_rvalid);
            chk1("d_rvalid",  bus.d_rvalid,  e_d_rvalid);
            chk1("err",       bus.err,       e_err);
            chk("if_rdata",   64'(bus.if_rdata), 64'(e_if_rdata));
            chk("d_rdata",    bus.d_rdata,   e_d_rdata);
            chk("mem_addr",   64'(bus.mem_addr), 64'(e_mem_addr));
            if (e_mem_en) chk1("mem_we", bus.mem_we, e_mem_we);
            if (e_mem_en && e_mem_we) chk("mem_wdata", bus.mem_wdata, e_mem_wdata);
        end
        // memory responder
        bus.mem_ack = 1'b0;
        if (ack_mode == 1) begin
            if (bus.mem_en) begin
                ack_pend = 1;
                ack_wait = 0;
            end
            if (ack_pend) begin
                if (ack_wait == ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = fix_rdata ? fix_val : {$urandom, $urandom};
                    ack_pend      = 0;
                end else begin
                    ack_wait++;
                end
            end
        end else if (ack_mode == 2) begin
            bus.mem_ack   = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = {$urandom, $urandom};
        end else begin
            ack_pend = 0;
        end
        // requesters
        if (rand_req) begin
            if (req_always) begin
                bus.if_req = 1'b1;
                bus.d_req  = 1'b1;
                if (bus.if_gnt) bus.if_addr = $urandom;
                if (bus.d_gnt) begin
                    bus.d_addr  = $urandom;
                    bus.d_we    = 1'($urandom_range(0, 1));
                    bus.d_wdata = {$urandom, $urandom};
                end
            end else begin
                if (!bus.if_req || bus.if_gnt) begin
                    bus.if_req  = ($urandom_range(0, 2) != 0);
                    bus.if_addr = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.if_req = 1'b0;  // withdrawn before grant
                end
                if (!bus.d_req || bus.d_gnt) begin
                    bus.d_req   = ($urandom_range(0, 2) != 0);
                    bus.d_we    = 1'($urandom_range(0, 1));
                    bus.d_addr  = $urandom;
                    bus.d_wdata = {$urandom, $urandom};
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.d_req = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_if_gnt"},    bus.if_gnt,    1'b0);
        chk1({tag, "_d_gnt"},     bus.d_gnt,     1'b0);
        chk1({tag, "_mem_en"},    bus.mem_en,    1'b0);
        chk1({tag, "_mem_we"},    bus.mem_we,    1'b0);
        chk1({tag, "_if_rvalid"}, bus.if_rvalid, 1'b0);
        chk1({tag, "_d_rvalid"},  bus.d_rvalid,  1'b0);
        chk1({tag, "_err"},       bus.err,       1'b0);
        chk({tag, "_if_rdata"},   64'(bus.if_rdata), 64'd0);
        chk({tag, "_d_rdata"},    bus.d_rdata,   64'd0);
        chk({tag, "_mem_addr"},   64'(bus.mem_addr), 64'd0);
        chk({tag, "_mem_wdata"},  bus.mem_wdata, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit    seen;
        int    cnt;
        string d_ord, m_ord, exp_ord;

        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 0; bus.mem_rdata = '0;

        // reset state
        drain(3);
        check_all_zero("rst");
        reset = 1'b1;
        ack_mode = 1; ack_delay = 1;
        drain(2);

        // 1: fetch only, ack one cycle after mem_en
        fix_rdata = 1; fix_val = 64'h1122334455667788;
        bus.if_req = 1; bus.if_addr = 32'h2000;
        tick();
        chk1("t1_if_gnt", bus.if_gnt, 1'b1);
        chk1("t1_mem_en", bus.mem_en, 1'b1);
        chk1("t1_mem_we", bus.mem_we, 1'b0);
        chk("t1_mem_addr", 64'(bus.mem_addr), 64'h2000);
        bus.if_req = 0;
        tick();
        chk1("t1_rvalid_early", bus.if_rvalid, 1'b0);
        tick();
        chk1("t1_if_rvalid", bus.if_rvalid, 1'b1);
        chk("t1_if_rdata", 64'(bus.if_rdata), 64'h55667788);
        chk("t1_model_rdata", 64'(e_if_rdata), 64'h55667788);
        drain(2);

        // 3: store
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h80; bus.d_wdata = 64'hDEADBEEF;
        tick();
        chk1("t3_d_gnt", bus.d_gnt, 1'b1);
        chk1("t3_mem_we", bus.mem_we, 1'b1);
        chk("t3_mem_wdata", bus.mem_wdata, 64'hDEADBEEF);
        chk("t3_mem_addr", 64'(bus.mem_addr), 64'h80);
        bus.d_req = 0; bus.d_we = 0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (bus.d_rvalid) seen = 1;
        end
        chk1("t3_rvalid_seen", seen, 1'b1);
        chk("t3_d_rdata", bus.d_rdata, 64'd0);
        chk1("t3_err", bus.err, 1'b0);
        drain(2);

        // 4: load with no acknowledge -> timeout, then normal service
        ack_mode = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
        tick();
        chk1("t4_d_gnt", bus.d_gnt, 1'b1);
        bus.d_req = 0;
        cnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            cnt++;
            if (bus.d_rvalid) seen = 1;
        end
        chk1("t4_rvalid_seen", seen, 1'b1);
        chk("t4_gnt_to_rvalid", 64'(cnt), 64'd16);
        chk1("t4_err", bus.err, 1'b1);
        chk("t4_d_rdata", bus.d_rdata, 64'd0);
        tick();
        chk1("t4_err_pulse", bus.err, 1'b0);
        chk1("t4_rvalid_pulse", bus.d_rvalid, 1'b0);
        ack_mode = 1; ack_delay = 1; fix_val = 64'h0BAD_F00D_CAFE_0001;
        bus.d_req = 1; bus.d_addr = 32'h108;
        tick();
        chk1("t4_next_gnt", bus.d_gnt, 1'b1);
        bus.d_req = 0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (bus.d_rvalid) seen = 1;
        end
        chk1("t4_next_seen", seen, 1'b1);
        chk1("t4_next_err", bus.err, 1'b0);
        chk("t4_next_rdata", bus.d_rdata, 64'h0BAD_F00D_CAFE_0001);
        drain(2);

        // 5: reset in BUSY_D drops the transaction
        ack_mode = 0;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
        tick();
        chk1("t5_d_gnt", bus.d_gnt, 1'b1);
        bus.d_req = 0;
        tick();
        #2 reset = 1'b0;
        #1 check_all_zero("t5_rst");
        drain(2);
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        chk1("t5_no_rvalid", bus.d_rvalid, 1'b0);
        chk1("t5_no_err", bus.err, 1'b0);
        ack_mode = 1; ack_delay = 1;
        bus.if_req = 1; bus.if_addr = 32'h400;
        tick();
        chk1("t5_if_gnt", bus.if_gnt, 1'b1);
        bus.if_req = 0;
        drain(4);

        // 6: ack in the same cycle as mem_en, then spurious ack while idle
        ack_delay = 0; fix_val = 64'hA5A5_0000_1234_5678;
        bus.if_req = 1; bus.if_addr = 32'h3000;
        tick();
        chk1("t6_if_gnt", bus.if_gnt, 1'b1);
        bus.if_req = 0;
        tick();
        chk1("t6_if_rvalid", bus.if_rvalid, 1'b1);
        chk("t6_if_rdata", 64'(bus.if_rdata), 64'h12345678);
        tick();
        ack_mode = 0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk1("t6_spur_rvalid", bus.if_rvalid, 1'b0);
        chk1("t6_spur_err", bus.err, 1'b0);
        chk("t6_spur_rdata", 64'(bus.if_rdata), 64'h12345678);
        tick();
        chk1("t6_spur_rvalid2", bus.if_rvalid | bus.d_rvalid, 1'b0);

        // 2: both requesting continuously, fresh starvation count
        #2 reset = 1'b0;
        drain(2);
        reset = 1'b1;
        ack_mode = 1; ack_delay = 1; fix_rdata = 0;
        rand_req = 1; req_always = 1;
        d_ord = ""; m_ord = "";
        for (int i = 0; i < 200 && d_ord.len() < 20; i++) begin
            tick();
            if (bus.d_gnt)  d_ord = {d_ord, "D"};
            if (bus.if_gnt) d_ord = {d_ord, "I"};
            if (e_d_gnt)    m_ord = {m_ord, "D"};
            if (e_if_gnt)   m_ord = {m_ord, "I"};
        end
        exp_ord = "DDDDIDDDDIDDDDIDDDDI";
        chk("t2_grant_count", 64'(d_ord.len()), 64'd20);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t2_dut_grant%0d", i), 64'(d_ord[i]), 64'(exp_ord[i]));
            chk($sformatf("t2_model_grant%0d", i), 64'(m_ord[i]), 64'(exp_ord[i]));
        end

        // randomized traffic: random requests, withdrawals, random acks incl. spurious and timeouts
        req_always = 0;
        ack_mode = 2;
        drain(4000);
        rand_req = 0;
        bus.if_req = 0; bus.d_req = 0;
        ack_mode = 1;
        drain(30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
